note_sequencer: RTL and testbench
=================================

# note_sequencer

Melody sequencer that sits directly upstream of the tone oscillator. It holds a small writable note table and, on `start`, steps through it entry by entry. For each entry it drives the oscillator's `freq`, a one-cycle `playSound` strobe and the ON/OFF `state`. Each note is held for a programmed number of duration units and followed by a short silent gap between notes.

## Interface
- `DEPTH`, 16: note-table entries, power of two.
- `TICKS_PER_UNIT`, 1000000: clock cycles per duration unit.
- `GAP_TICKS`, 100000: silent cycles after each note, ≥1.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin playback from entry 0. Honoured only in IDLE.
- `stop` in 1: abort playback. Honoured in every state.
- `loop` in 1: replay from entry 0 at end of song. Ignored unless `NOTE_SEQ_LOOP_EN` is defined.
- `wr_en` in 1: note-table write strobe.
- `wr_addr` in $clog2(DEPTH): write entry index.
- `wr_freq` in 8: oscillator period value. 0 means rest.
- `wr_len` in 4: duration in units. 0 means end-of-song marker.
- `freq` out 8: period value to the oscillator.
- `playSound` out 1: one-cycle strobe at the start of each non-rest note.
- `state` out MODE_TYPES: ON while a non-rest note is held, otherwise OFF.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse on natural end of song.
- `note_idx` out $clog2(DEPTH): index of the current entry.

## Operation
- **Table:** DEPTH × {freq[7:0], len[3:0]} registers.
  - `rst` clears all entries to 0.
  - A write lands at the clock edge where `wr_en`=1 and is accepted in any FSM state.
  - A write to the entry currently playing takes effect the next time that entry is loaded.
- **FSM states:** IDLE, LOAD, HOLD, GAP.
- **IDLE:**
  - On `start`=1 and `stop`=0: go to LOAD with `note_idx`=0.
- **LOAD:** reads entry `note_idx`.
  - If len=0, finish (see end-of-song rules below).
  - Otherwise register `freq`=entry.freq and go to HOLD.
  - If entry.freq≠0: `playSound`=1 and `state`=ON for the first HOLD cycle.
  - If entry.freq=0 (rest): no strobe; `state`=OFF; `freq` keeps its previous value.
- **HOLD:** lasts exactly len×TICKS_PER_UNIT cycles, then go to GAP.
  - Counters: unit counter 0..TICKS_PER_UNIT-1 and unit-remaining counter 4 bits.
- **GAP:** `state`=OFF for GAP_TICKS cycles.
  - If `note_idx`=DEPTH-1: finish.
  - Otherwise `note_idx`+1 and go to LOAD.
- **Finish:**
  - Pulse `done`=1 for one cycle and go to IDLE with `note_idx`=0.
  - Loop exception (only when `NOTE_SEQ_LOOP_EN` is defined): if `loop`=1 and entry 0 has len≠0, go to LOAD with `note_idx`=0 and do not pulse `done`.
- **`stop`:**
  - In any state: next state IDLE, `state`=OFF, `freq`=0, `note_idx`=0, no `done`.
  - `stop` wins over a simultaneous `start`.
- `start` while `busy` is ignored.
- `playSound` is never asserted in two consecutive cycles.

## Timing
- **Reset values:** `freq`=0, `playSound`=0, `state`=OFF, `busy`=0, `done`=0, `note_idx`=0, FSM=IDLE.
- `rst` mid-playback behaves exactly like reset; the table is also cleared.
- **Start latency:**
  - `start` sampled at edge k → LOAD at k+1 → `freq` valid and `playSound`=1 from edge k+2.
  - `busy`=1 from edge k+1.
- **Per-note period:** 1 (LOAD) + len×TICKS_PER_UNIT (HOLD) + GAP_TICKS (GAP) cycles.
- **End marker:** reaching an end marker costs one LOAD cycle; `done` is high the cycle after that LOAD.
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- **`NOTE_SEQ_LOOP_EN` defined:** `loop` is honoured at end of song as described in Operation.
- **Not defined:**
  - `loop` is ignored.
  - The finish path always pulses `done` and returns to IDLE.
  - The loop branch is not synthesised.

## Test plan
Bench parameters: TICKS_PER_UNIT=4, GAP_TICKS=2, DEPTH=4.
- **Reset, then `start` with an all-zero table:** `busy` high for one cycle; `done` pulses 2 cycles after `start`; `playSound` never asserted.
- **Table {(50,2),(0,1),(80,1),(x,0)}, then `start`:**
  - `freq`=50 with `playSound` 2 cycles after `start`; 8 HOLD cycles with `state`=ON; 2 GAP cycles.
  - Rest entry: 4 cycles with `state`=OFF and no strobe.
  - `freq`=80 with `playSound`, then `done`.
- **`stop` mid-HOLD of note 0:** next cycle `state`=OFF, `freq`=0, `busy`=0; `done` stays 0.
- **`start` and `stop` asserted in the same cycle from IDLE:** FSM remains IDLE.
- **All 4 entries len=1 (no end marker):** `done` after the GAP of entry 3; `note_idx` returns to 0.
- **`NOTE_SEQ_LOOP_EN` defined, `loop`=1:** playback restarts at entry 0 with no `done`. Deassert `loop` → `done` at the following end of song.

Source files
------------

// File: rtl/note_sequencer.sv
// Melody sequencer: steps through a writable note table and drives freq/playSound/state to the tone oscillator.
// Optional feature: define NOTE_SEQ_LOOP_EN to honour loop_i at end of song.
package note_seq_pkg;
  typedef enum logic {OFF = 1'b0, ON = 1'b1} mode_t;
endpackage

module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int TICKS_PER_UNIT = 1000000,
  parameter int GAP_TICKS      = 100000,
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          loop_i,
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_addr_i,
  input  logic [7:0]    wr_freq_i,
  input  logic [3:0]    wr_len_i,
  output logic [7:0]    freq_o,
  output logic          playSound_o,
  output mode_t         state_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [IW-1:0] note_idx_o
);

  localparam int UW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [UW-1:0] UNIT_LAST = UW'(TICKS_PER_UNIT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_TICKS - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, GAP} fsm_t;

  fsm_t          fsm_q, fsm_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    freq_q, freq_d;
  logic          play_q, play_d;
  mode_t         mode_q, mode_d;
  logic          done_q, done_d;
  logic [UW-1:0] unit_q, unit_d;
  logic [3:0]    left_q, left_d;
  logic [GW-1:0] gap_q, gap_d;

  logic [7:0] tblFreq_q [DEPTH];
  logic [3:0] tblLen_q  [DEPTH];

  logic [7:0] curFreq;
  logic [3:0] curLen;
  logic       finish;
  logic       loopGo;

  assign curFreq = tblFreq_q[idx_q];
  assign curLen  = tblLen_q[idx_q];

`ifdef NOTE_SEQ_LOOP_EN
  assign loopGo = loop_i && (tblLen_q[0] != 4'd0);
`else
  logic unusedLoop;
  assign unusedLoop = loop_i;
  assign loopGo     = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        tblFreq_q[i] <= 8'd0;
        tblLen_q[i]  <= 4'd0;
      end
    end else if (wr_en_i) begin
      tblFreq_q[wr_addr_i] <= wr_freq_i;
      tblLen_q[wr_addr_i]  <= wr_len_i;
    end
  end

  always_comb begin
    fsm_d  = fsm_q;
    idx_d  = idx_q;
    freq_d = freq_q;
    play_d = 1'b0;
    mode_d = mode_q;
    done_d = 1'b0;
    unit_d = unit_q;
    left_d = left_q;
    gap_d  = gap_q;
    finish = 1'b0;

    if (stop_i) begin
      fsm_d  = IDLE;
      idx_d  = '0;
      freq_d = 8'd0;
      mode_d = OFF;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (start_i) begin
            fsm_d = LOAD;
            idx_d = '0;
          end
        end
        LOAD: begin
          if (curLen == 4'd0) begin
            finish = 1'b1;
          end else begin
            fsm_d  = HOLD;
            unit_d = '0;
            left_d = curLen;
            // A rest keeps the previous freq so the oscillator input stays stable
            if (curFreq != 8'd0) begin
              freq_d = curFreq;
              play_d = 1'b1;
              mode_d = ON;
            end else begin
              mode_d = OFF;
            end
          end
        end
        HOLD: begin
          if (unit_q == UNIT_LAST) begin
            unit_d = '0;
            left_d = left_q - 4'd1;
            if (left_q == 4'd1) begin
              fsm_d  = GAP;
              gap_d  = '0;
              mode_d = OFF;
            end
          end else begin
            unit_d = unit_q + UW'(1);
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            if (idx_q == IDX_LAST) begin
              finish = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
              fsm_d = LOAD;
            end
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
        default: fsm_d = IDLE;
      endcase

      // Shared end-of-song handling for both the end marker and the last entry
      if (finish) begin
        idx_d = '0;
        if (loopGo) begin
          fsm_d = LOAD;
        end else begin
          fsm_d  = IDLE;
          done_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q  <= IDLE;
      idx_q  <= '0;
      freq_q <= 8'd0;
      play_q <= 1'b0;
      mode_q <= OFF;
      done_q <= 1'b0;
      unit_q <= '0;
      left_q <= 4'd0;
      gap_q  <= '0;
    end else begin
      fsm_q  <= fsm_d;
      idx_q  <= idx_d;
      freq_q <= freq_d;
      play_q <= play_d;
      mode_q <= mode_d;
      done_q <= done_d;
      unit_q <= unit_d;
      left_q <= left_d;
      gap_q  <= gap_d;
    end
  end

  assign freq_o      = freq_q;
  assign playSound_o = play_q;
  assign state_o     = mode_q;
  assign busy_o      = (fsm_q != IDLE);
  assign done_o      = done_q;
  assign note_idx_o  = idx_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed self-checking bench for note_sequencer with DEPTH=4, TICKS_PER_UNIT=4, GAP_TICKS=2.
// The loop scenario is compiled only when NOTE_SEQ_LOOP_EN is defined.
module tb_note_sequencer;
  import note_seq_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic       stop_i = 1'b0;
  logic       loop_i = 1'b0;
  logic       wr_en_i = 1'b0;
  logic [1:0] wr_addr_i = 2'd0;
  logic [7:0] wr_freq_i = 8'd0;
  logic [3:0] wr_len_i = 4'd0;
  logic [7:0] freq_o;
  logic       playSound_o;
  mode_t      state_o;
  logic       busy_o;
  logic       done_o;
  logic [1:0] note_idx_o;

  int compareCount = 0;
  int mismatchCount = 0;

  note_sequencer #(
    .DEPTH(4),
    .TICKS_PER_UNIT(4),
    .GAP_TICKS(2)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .start_i(start_i),
    .stop_i(stop_i),
    .loop_i(loop_i),
    .wr_en_i(wr_en_i),
    .wr_addr_i(wr_addr_i),
    .wr_freq_i(wr_freq_i),
    .wr_len_i(wr_len_i),
    .freq_o(freq_o),
    .playSound_o(playSound_o),
    .state_o(state_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .note_idx_o(note_idx_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] addr, input logic [7:0] freq, input logic [3:0] len);
    wr_en_i   = 1'b1;
    wr_addr_i = addr;
    wr_freq_i = freq;
    wr_len_i  = len;
    tick();
    wr_en_i   = 1'b0;
  endtask

  initial begin
    int earlyDone;
    logic expOn, expPlay, expDone, expBusy;

    // Reset
    tick();
    tick();
    checkOutput("rst_freq", 32'(freq_o), 32'd0);
    checkOutput("rst_play", 32'(playSound_o), 32'd0);
    checkOutput("rst_state", 32'(state_o), 32'(OFF));
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_done", 32'(done_o), 32'd0);
    checkOutput("rst_idx", 32'(note_idx_o), 32'd0);
    rst_i = 1'b0;
    tick();

    // Empty table: immediate end marker
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checkOutput("empty_busy1", 32'(busy_o), 32'd1);
    checkOutput("empty_done1", 32'(done_o), 32'd0);
    checkOutput("empty_play1", 32'(playSound_o), 32'd0);
    tick();
    checkOutput("empty_busy2", 32'(busy_o), 32'd0);
    checkOutput("empty_done2", 32'(done_o), 32'd1);
    checkOutput("empty_play2", 32'(playSound_o), 32'd0);
    tick();
    checkOutput("empty_done3", 32'(done_o), 32'd0);

    // Song {(50,2),(0,1),(80,1),(7,0)}
    applyStimulus(2'd0, 8'd50, 4'd2);
    applyStimulus(2'd1, 8'd0, 4'd1);
    applyStimulus(2'd2, 8'd80, 4'd1);
    applyStimulus(2'd3, 8'd7, 4'd0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checkOutput("song_busy_c1", 32'(busy_o), 32'd1);
    checkOutput("song_play_c1", 32'(playSound_o), 32'd0);
    for (int c = 2; c <= 28; c++) begin
      tick();
      expOn   = ((c >= 2) && (c <= 9)) || ((c >= 20) && (c <= 23));
      expPlay = (c == 2) || (c == 20);
      expDone = (c == 27);
      expBusy = (c < 27);
      checkOutput($sformatf("song_state_c%0d", c), 32'(state_o), expOn ? 32'(ON) : 32'(OFF));
      checkOutput($sformatf("song_play_c%0d", c), 32'(playSound_o), 32'(expPlay));
      checkOutput($sformatf("song_done_c%0d", c), 32'(done_o), 32'(expDone));
      checkOutput($sformatf("song_busy_c%0d", c), 32'(busy_o), 32'(expBusy));
      if (c == 2) checkOutput("song_freq_n0", 32'(freq_o), 32'd50);
      if ((c >= 13) && (c <= 16)) checkOutput($sformatf("song_freq_rest_c%0d", c), 32'(freq_o), 32'd50);
      if (c == 20) checkOutput("song_freq_n2", 32'(freq_o), 32'd80);
      if (c == 12) checkOutput("song_idx1", 32'(note_idx_o), 32'd1);
      if (c == 19) checkOutput("song_idx2", 32'(note_idx_o), 32'd2);
      if (c == 26) checkOutput("song_idx3", 32'(note_idx_o), 32'd3);
      if (c == 27) checkOutput("song_idx_end", 32'(note_idx_o), 32'd0);
    end

    // Stop mid-HOLD of note 0
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("stop_pre_state", 32'(state_o), 32'(ON));
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    checkOutput("stop_state", 32'(state_o), 32'(OFF));
    checkOutput("stop_freq", 32'(freq_o), 32'd0);
    checkOutput("stop_busy", 32'(busy_o), 32'd0);
    checkOutput("stop_done", 32'(done_o), 32'd0);
    checkOutput("stop_idx", 32'(note_idx_o), 32'd0);
    tick();
    checkOutput("stop_done2", 32'(done_o), 32'd0);
    checkOutput("stop_busy2", 32'(busy_o), 32'd0);

    // Start and stop together from IDLE
    start_i = 1'b1;
    stop_i  = 1'b1;
    tick();
    start_i = 1'b0;
    stop_i  = 1'b0;
    checkOutput("ss_busy1", 32'(busy_o), 32'd0);
    tick();
    checkOutput("ss_busy2", 32'(busy_o), 32'd0);
    checkOutput("ss_play", 32'(playSound_o), 32'd0);
    checkOutput("ss_done", 32'(done_o), 32'd0);

    // All four entries len=1, no end marker
    applyStimulus(2'd0, 8'd10, 4'd1);
    applyStimulus(2'd1, 8'd20, 4'd1);
    applyStimulus(2'd2, 8'd30, 4'd1);
    applyStimulus(2'd3, 8'd40, 4'd1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    earlyDone = 0;
    for (int c = 2; c <= 29; c++) begin
      tick();
      if (c == 2) checkOutput("full_freq0", 32'(freq_o), 32'd10);
      if (c == 22) checkOutput("full_idx3", 32'(note_idx_o), 32'd3);
      if (c == 23) checkOutput("full_freq3", 32'(freq_o), 32'd40);
      if (c == 23) checkOutput("full_play3", 32'(playSound_o), 32'd1);
      if ((c < 29) && done_o) earlyDone++;
    end
    checkOutput("full_early_done", 32'(earlyDone), 32'd0);
    checkOutput("full_done", 32'(done_o), 32'd1);
    checkOutput("full_idx", 32'(note_idx_o), 32'd0);
    checkOutput("full_busy", 32'(busy_o), 32'd0);
    tick();

`ifdef NOTE_SEQ_LOOP_EN
    // Loop replays from entry 0 without done, then finishes once loop drops
    loop_i  = 1'b1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    earlyDone = 0;
    for (int c = 2; c <= 29; c++) begin
      tick();
      if (done_o) earlyDone++;
    end
    checkOutput("loop_no_done", 32'(earlyDone), 32'd0);
    checkOutput("loop_busy", 32'(busy_o), 32'd1);
    checkOutput("loop_idx", 32'(note_idx_o), 32'd0);
    loop_i = 1'b0;
    earlyDone = 0;
    for (int c = 30; c <= 57; c++) begin
      tick();
      if (c == 30) checkOutput("loop_play_again", 32'(playSound_o), 32'd1);
      if ((c < 57) && done_o) earlyDone++;
    end
    checkOutput("loop_early_done", 32'(earlyDone), 32'd0);
    checkOutput("loop_done", 32'(done_o), 32'd1);
    checkOutput("loop_end_busy", 32'(busy_o), 32'd0);
    tick();
`endif

    // Reset mid-playback also clears the table
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checkOutput("midrst_busy", 32'(busy_o), 32'd0);
    checkOutput("midrst_freq", 32'(freq_o), 32'd0);
    checkOutput("midrst_state", 32'(state_o), 32'(OFF));
    checkOutput("midrst_idx", 32'(note_idx_o), 32'd0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checkOutput("midrst_busy2", 32'(busy_o), 32'd1);
    tick();
    checkOutput("midrst_cleared_done", 32'(done_o), 32'd1);
    checkOutput("midrst_cleared_play", 32'(playSound_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
